// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction and boundary-mode encodings for counters
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/prog_ud_counter_next.sv
// rtl/prog_ud_counter_next.sv - combinational next count, terminal count and wrap event
module prog_ud_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic             dir,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_count,
  output logic             next_tc,
  output logic             wrap
);

  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    wrap       = 1'b0;
    if (count > max_val) begin
      // max_val was lowered below the count: clamp silently, not a boundary event
      next_count = max_val;
    end else if (dir == DIR_DOWN) begin
      if (count == '0) begin
        next_tc = 1'b1;
        if (sat_mode == MODE_WRAP) begin
          next_count = max_val;
          wrap       = 1'b1;
        end
      end else begin
        next_count = count - 1'b1;
      end
    end else begin
      if (count == max_val) begin
        next_tc = 1'b1;
        if (sat_mode == MODE_WRAP) begin
          next_count = '0;
          wrap       = 1'b1;
        end
      end else begin
        next_count = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_ud_counter.sv
// rtl/prog_ud_counter.sv - programmable up/down counter with wrap/saturate and sticky overflow
module prog_ud_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] next_count;
  logic             next_tc;
  logic             wrap;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_event;

  prog_ud_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count      (count),
    .max_val    (max_val),
    .dir        (dir),
    .sat_mode   (sat_mode),
    .next_count (next_count),
    .next_tc    (next_tc),
    .wrap       (wrap)
  );

  assign load_clamped = (load_val > max_val) ? max_val : load_val;
  assign wrap_event   = en && !load && wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= WIDTH'(RESET_VAL);
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
    end else if (en) begin
      count <= next_count;
      tc    <= next_tc;
    end else begin
      tc    <= 1'b0;
    end
  end

  // a wrap in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wrap_event) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign at_max  = (count == max_val);
  assign at_zero = (count == '0);

endmodule

// File: doc/prog_ud_counter.md
PROG_UD_COUNTER -- requirements
Module: prog_ud_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: value of count after reset; it SHALL be <= 2**WIDTH-1.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable: one step per cycle while high.
REQ-006 load  input  1  parallel load request.
REQ-007 load_val  input  WIDTH  value captured on load.
REQ-008 dir  input  1  direction: 0 = up, 1 = down.
REQ-009 sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-010 max_val  input  WIDTH  terminal value; the counting range is 0..max_val inclusive.
REQ-011 clr_ovf  input  1  clears the sticky ovf flag.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 tc  output  1  terminal-count pulse, registered.
REQ-014 ovf  output  1  sticky wrap flag, registered.
REQ-015 at_max, at_zero  output  1 each  combinational flags: (count == max_val) and (count == 0).

Function
REQ-016 Priority SHALL be reset > load > en; with en low and no load, count holds.
REQ-017 Load: count <= min(load_val, max_val); tc <= 0; ovf is unaffected.
REQ-018 Up step, count < max_val: count <= count + 1.
REQ-019 Up step, count == max_val: in wrap mode count <= 0 and ovf <= 1; in saturate mode count holds.
REQ-020 Down step, count > 0: count <= count - 1.
REQ-021 Down step, count == 0: in wrap mode count <= max_val and ovf <= 1; in saturate mode count holds at 0.
REQ-022 Enabled step with count > max_val (max_val lowered at runtime), either direction: count <= max_val; no tc; no ovf.
REQ-023 tc SHALL be 1 for the cycle following any enabled step whose pre-step count equals the boundary (max_val when up, 0 when down), in both modes; otherwise tc = 0.
REQ-024 tc therefore repeats every enabled cycle while saturated at the boundary.
REQ-025 tc and the new count value SHALL appear on the same edge (one-cycle latency from en).
REQ-026 ovf: set on a wrap event, cleared by clr_ovf; set wins when both occur in the same cycle.
REQ-027 max_val == 0: every enabled step is a boundary step: count stays 0, tc = 1, and ovf sets in wrap mode.
REQ-028 Arithmetic is modulo 2**WIDTH; no intermediate result SHALL exceed WIDTH+1 bits.
REQ-029 dir, sat_mode and max_val are sampled every cycle; changing them mid-count SHALL take effect on the next step.

Reset
REQ-030 When reset is high at a clk edge: count <= RESET_VAL, tc <= 0, ovf <= 0.
REQ-031 Reset mid-operation discards any load or step in the same cycle.
REQ-032 No output SHALL be X after the first reset edge.

Structure
REQ-033 Shared package counter_pkg SHALL hold the direction encodings (DIR_UP=0, DIR_DOWN=1) and mode encodings (MODE_WRAP=0, MODE_SAT=1).
REQ-034 The combinational next-state computation (next count, tc, wrap event) SHALL be a single sub-module, prog_ud_counter_next; the top level holds the registers and the ovf logic.

Verification (WIDTH=8, RESET_VAL=0)
REQ-035 Wrap up: max_val=9, dir=0, en=1 for 12 cycles from 0 -> count 1..9, 0, 1, 2; tc=1 only with the first count=0; ovf=1 thereafter.
REQ-036 Wrap down: max_val=9, dir=1, from count 0 -> count=9, tc=1, ovf=1; then 8, 7 with tc=0.
REQ-037 Saturate: sat_mode=1, max_val=9, up from 7 -> 8, 9, 9, 9; tc=1 on each step taken from 9; ovf stays 0.
REQ-038 Load: load_val=200, max_val=9 -> count=9; load and en high together with load_val=4 -> count=4, with no step applied.
REQ-039 Runtime limit: count=7, max_val changed 9->3, en pulse -> count=3, tc=0, ovf unchanged.
REQ-040 Reset and clear: reset at count=5 -> count=0, tc=0, ovf=0; clr_ovf high in the same cycle as a wrap -> ovf=1.
